regfile_writeback_arbiter: RTL and testbench

//  Writer side of the register file. Merges result streams from two producers (ALU, load unit)

---
 rtl/regfile_writeback_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter.sv
// Purpose : merges ALU (A) and load (B) results into the register file's single write port
//           through a DEPTH-entry in-order FIFO, and answers bypass lookups for queued writes.
// Latency : an entry accepted at edge N can commit at the end of cycle N+1 at the earliest.
// Backpr. : AReady/BReady drop when the FIFO is full and not popping; A wins ties unless B
//           has been denied STARVE_LIMIT consecutive cycles, in which case B wins that cycle.
// Ports   :
//   clk, reset              rising-edge clock, synchronous active-low reset
//   AValid/AReady/AAdr/AData  ALU result handshake
//   BValid/BReady/BAdr/BData  load result handshake
//   DrainEn                 write port available; WriteEn/rd1Adr/Rd1 drive the register file
//   rs1Adr/rs2Adr           bypass lookups -> Rs1Hit/Rs1Fwd, Rs2Hit/Rs2Fwd (youngest match)
//   Full                    FIFO holds DEPTH entries
module regfile_writeback_arbiter #(
  parameter int REGISTER_COUNT = 32,
  parameter int DEPTH          = 4,
  parameter int STARVE_LIMIT   = 3,
  parameter int XLEN           = 32,
  localparam int AW            = $clog2(REGISTER_COUNT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            AValid,
  output logic            AReady,
  input  logic [AW-1:0]   AAdr,
  input  logic [XLEN-1:0] AData,
  input  logic            BValid,
  output logic            BReady,
  input  logic [AW-1:0]   BAdr,
  input  logic [XLEN-1:0] BData,
  input  logic            DrainEn,
  output logic            WriteEn,
  output logic [AW-1:0]   rd1Adr,
  output logic [XLEN-1:0] Rd1,
  input  logic [AW-1:0]   rs1Adr,
  input  logic [AW-1:0]   rs2Adr,
  output logic            Rs1Hit,
  output logic            Rs2Hit,
  output logic [XLEN-1:0] Rs1Fwd,
  output logic [XLEN-1:0] Rs2Fwd,
  output logic            Full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0]   adr_mem [DEPTH];
  logic [XLEN-1:0] dat_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [SW-1:0] starve_q;

  logic            space;
  logic            starved;
  logic            a_acc;
  logic            b_acc;
  logic            push_q;
  logic [AW-1:0]   push_adr;
  logic [XLEN-1:0] push_dat;

  // Pop side: the head is presented combinationally and leaves on a WriteEn edge.
  assign WriteEn = DrainEn && (count_q != '0);
  assign rd1Adr  = adr_mem[rd_ptr];
  assign Rd1     = dat_mem[rd_ptr];
  assign Full    = (count_q == CW'(DEPTH));

  // A pop in the same cycle frees a slot, so a full FIFO can still take one entry.
  assign space   = (count_q < CW'(DEPTH)) || WriteEn;
  assign starved = (starve_q == SW'(STARVE_LIMIT));

  // Each ready depends only on space, the starve state and the other port's valid,
  // never on the other port's ready, so there is no combinational loop between them.
  assign AReady = starved ? (space && !BValid) : space;
  assign BReady = starved ? space : (space && !AValid);

  assign a_acc    = AValid && AReady;
  assign b_acc    = BValid && BReady;
  assign push_adr = a_acc ? AAdr : BAdr;
  assign push_dat = a_acc ? AData : BData;
  // x0 writes complete the handshake but never occupy a slot.
  assign push_q   = (a_acc || b_acc) && (push_adr != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_q) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (WriteEn) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_q, WriteEn})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Slot contents need no reset: validity is entirely defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_q) begin
      adr_mem[wr_ptr] <= push_adr;
      dat_mem[wr_ptr] <= push_dat;
    end
  end

  // Counts consecutive cycles in which B was denied although a slot was available.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (!BValid || b_acc) begin
      starve_q <= '0;
    end else if (space && !BReady && !starved) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  // Bypass: walk stored entries oldest to youngest so the youngest match wins.
  // The head still counts while it pops; the entry being pushed is not yet stored.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    Rs1Hit = 1'b0;
    Rs2Hit = 1'b0;
    Rs1Fwd = '0;
    Rs2Fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count_q) begin
        if ((rs1Adr != '0) && (adr_mem[idx] == rs1Adr)) begin
          Rs1Hit = 1'b1;
          Rs1Fwd = dat_mem[idx];
        end
        if ((rs2Adr != '0) && (adr_mem[idx] == rs2Adr)) begin
          Rs2Hit = 1'b1;
          Rs2Fwd = dat_mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Purpose : self-checking bench for regfile_writeback_arbiter; a scoreboard queue follows
//           accepted non-x0 writes and is matched against every register file commit.
// Latency : stimulus is applied 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpr. : the bench obeys AReady/BReady; only handshakes that complete enter the scoreboard.
module tb_regfile_writeback_arbiter;

  localparam int AW   = 5;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [AW-1:0]   adr;
    logic [XLEN-1:0] dat;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            AValid, AReady, BValid, BReady;
  logic [AW-1:0]   AAdr, BAdr, rd1Adr, rs1Adr, rs2Adr;
  logic [XLEN-1:0] AData, BData, Rd1, Rs1Fwd, Rs2Fwd;
  logic            DrainEn, WriteEn, Rs1Hit, Rs2Hit, Full;

  int total = 0;
  int bad   = 0;
  wr_t sb[$];

  regfile_writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .AValid(AValid), .AReady(AReady), .AAdr(AAdr), .AData(AData),
    .BValid(BValid), .BReady(BReady), .BAdr(BAdr), .BData(BData),
    .DrainEn(DrainEn), .WriteEn(WriteEn), .rd1Adr(rd1Adr), .Rd1(Rd1),
    .rs1Adr(rs1Adr), .rs2Adr(rs2Adr), .Rs1Hit(Rs1Hit), .Rs2Hit(Rs2Hit),
    .Rs1Fwd(Rs1Fwd), .Rs2Fwd(Rs2Fwd), .Full(Full)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: commits pop and compare, completed handshakes push; a reset flushes it.
  always @(negedge clk) begin
    wr_t exp_w;
    if (!reset) begin
      sb.delete();
    end else begin
      if (WriteEn) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL commit_unexpected got adr=%0d dat=%h want no commit", rd1Adr, Rd1);
        end else begin
          exp_w = sb.pop_front();
          if ({rd1Adr, Rd1} !== {exp_w.adr, exp_w.dat}) begin
            bad++;
            $display("FAIL commit_data got adr=%0d dat=%h want adr=%0d dat=%h",
                     rd1Adr, Rd1, exp_w.adr, exp_w.dat);
          end
        end
      end
      if (AValid && AReady && AAdr != '0) sb.push_back('{adr: AAdr, dat: AData});
      if (BValid && BReady && BAdr != '0) sb.push_back('{adr: BAdr, dat: BData});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; AValid = 1'b0; BValid = 1'b0; DrainEn = 1'b1;
    AAdr = '0; BAdr = '0; AData = '0; BData = '0;
    rs1Adr = 5'd5; rs2Adr = 5'd7;
    repeat (2) next_cycle();
    mid();
    total++;
    if ({WriteEn, Full, Rs1Hit, Rs2Hit} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got we/full/h1/h2=%b want 0000", {WriteEn, Full, Rs1Hit, Rs2Hit});
    end
    total++;
    if ({Rs1Fwd, Rs2Fwd} !== 64'd0) begin
      bad++;
      $display("FAIL reset_fwd got %h %h want 0 0", Rs1Fwd, Rs2Fwd);
    end
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_single_push();
    DrainEn = 1'b1; AValid = 1'b1; AAdr = 5'd5; AData = 32'h11;
    mid();
    total++;
    if (AReady !== 1'b1 || WriteEn !== 1'b0) begin
      bad++;
      $display("FAIL single_accept got ready=%b we=%b want 1 0", AReady, WriteEn);
    end
    next_cycle();
    AValid = 1'b0;
    mid();
    total++;
    if (WriteEn !== 1'b1 || rd1Adr !== 5'd5 || Rd1 !== 32'h11) begin
      bad++;
      $display("FAIL single_commit got we=%b adr=%0d dat=%h want 1 5 11", WriteEn, rd1Adr, Rd1);
    end
    next_cycle();
    mid();
    total++;
    if (WriteEn !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got we=%b want 0", WriteEn);
    end
    next_cycle();
  endtask

  task automatic test_full_drain();
    logic [AW-1:0] exp_ord [4] = '{5'd2, 5'd3, 5'd4, 5'd6};
    DrainEn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      AValid = 1'b1; AAdr = AW'(i); AData = 32'h100 + i;
      mid();
      next_cycle();
    end
    AAdr = 5'd6; AData = 32'h106;
    mid();
    total++;
    if (Full !== 1'b1 || AReady !== 1'b0) begin
      bad++;
      $display("FAIL full_block got full=%b ready=%b want 1 0", Full, AReady);
    end
    next_cycle();
    DrainEn = 1'b1;
    mid();
    total++;
    if (AReady !== 1'b1 || WriteEn !== 1'b1 || rd1Adr !== 5'd1) begin
      bad++;
      $display("FAIL full_pop_push got ready=%b we=%b adr=%0d want 1 1 1", AReady, WriteEn, rd1Adr);
    end
    next_cycle();
    AValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      total++;
      if (WriteEn !== 1'b1 || rd1Adr !== exp_ord[k]) begin
        bad++;
        $display("FAIL drain_order[%0d] got we=%b adr=%0d want 1 %0d", k, WriteEn, rd1Adr, exp_ord[k]);
      end
      next_cycle();
    end
    mid();
    total++;
    if (WriteEn !== 1'b0 || Full !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty got we=%b full=%b want 0 0", WriteEn, Full);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_b;
    DrainEn = 1'b1; AValid = 1'b1; BValid = 1'b1; BAdr = 5'd20;
    for (int c = 0; c < 5; c++) begin
      AAdr = AW'(10 + c); AData = 32'h200 + c; BData = 32'h300 + c;
      exp_b = (c == 3);
      mid();
      total++;
      if (BReady !== exp_b || AReady !== !exp_b) begin
        bad++;
        $display("FAIL starve_cycle%0d got a=%b b=%b want a=%b b=%b", c, AReady, BReady, !exp_b, exp_b);
      end
      next_cycle();
    end
    AValid = 1'b0; BValid = 1'b0;
    repeat (3) begin
      mid();
      next_cycle();
    end
  endtask

  task automatic test_bypass();
    DrainEn = 1'b0; rs1Adr = 5'd7; rs2Adr = 5'd0;
    AValid = 1'b1; AAdr = 5'd7; AData = 32'hA;
    mid();
    total++;
    if (Rs1Hit !== 1'b0) begin
      bad++;
      $display("FAIL bypass_inflight got hit=%b want 0", Rs1Hit);
    end
    next_cycle();
    AData = 32'hB;
    mid();
    total++;
    if (Rs1Hit !== 1'b1 || Rs1Fwd !== 32'hA) begin
      bad++;
      $display("FAIL bypass_first got hit=%b fwd=%h want 1 a", Rs1Hit, Rs1Fwd);
    end
    next_cycle();
    AValid = 1'b0;
    mid();
    total++;
    if (Rs1Hit !== 1'b1 || Rs1Fwd !== 32'hB) begin
      bad++;
      $display("FAIL bypass_youngest got hit=%b fwd=%h want 1 b", Rs1Hit, Rs1Fwd);
    end
    total++;
    if (Rs2Hit !== 1'b0 || Rs2Fwd !== 32'h0) begin
      bad++;
      $display("FAIL bypass_x0 got hit=%b fwd=%h want 0 0", Rs2Hit, Rs2Fwd);
    end
    rs2Adr = 5'd9;
    #1;
    total++;
    if (Rs2Hit !== 1'b0 || Rs2Fwd !== 32'h0) begin
      bad++;
      $display("FAIL bypass_miss got hit=%b fwd=%h want 0 0", Rs2Hit, Rs2Fwd);
    end
    next_cycle();
    DrainEn = 1'b1;
    mid();
    next_cycle();
    mid();
    total++;
    if (WriteEn !== 1'b1 || Rs1Hit !== 1'b1 || Rs1Fwd !== 32'hB) begin
      bad++;
      $display("FAIL bypass_popping got we=%b hit=%b fwd=%h want 1 1 b", WriteEn, Rs1Hit, Rs1Fwd);
    end
    next_cycle();
    mid();
    total++;
    if (Rs1Hit !== 1'b0 || Rs1Fwd !== 32'h0) begin
      bad++;
      $display("FAIL bypass_gone got hit=%b fwd=%h want 0 0", Rs1Hit, Rs1Fwd);
    end
    next_cycle();
  endtask

  task automatic test_x0();
    DrainEn = 1'b1; AValid = 1'b1; AAdr = 5'd0; AData = 32'hFF;
    mid();
    total++;
    if (AReady !== 1'b1) begin
      bad++;
      $display("FAIL x0_accept got ready=%b want 1", AReady);
    end
    next_cycle();
    AValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      total++;
      if (WriteEn !== 1'b0 || Full !== 1'b0) begin
        bad++;
        $display("FAIL x0_no_commit[%0d] got we=%b full=%b want 0 0", i, WriteEn, Full);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    DrainEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      AValid = 1'b1; AAdr = AW'(11 + i); AData = 32'h400 + i;
      mid();
      next_cycle();
    end
    AValid = 1'b0; reset = 1'b0; rs1Adr = 5'd11; rs2Adr = 5'd12;
    mid();
    next_cycle();
    reset = 1'b1; DrainEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      total++;
      if ({WriteEn, Rs1Hit, Rs2Hit, Full} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_mid[%0d] got we/h1/h2/full=%b want 0000", i, {WriteEn, Rs1Hit, Rs2Hit, Full});
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full_drain();
    test_starvation();
    test_bypass();
    test_x0();
    test_reset_mid();
    mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
